// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue: root kept in a register, levels 1.. stored
// as sibling-pair words in one BRAM per level with half write enables.
module bram_heap_pq #(
  parameter int TREE_DEPTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit MAX_HEAP   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_write,
  input  logic                  i_read,
  input  logic                  i_replace,
  input  logic [DATA_WIDTH-1:0] i_new_item,
  output logic                  o_ready,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [TREE_DEPTH-1:0] o_count,
  output logic [DATA_WIDTH-1:0] o_top_item
);
  localparam int D  = TREE_DEPTH;
  localparam int W  = DATA_WIDTH;
  localparam int LW = (D > 1) ? $clog2(D) : 1;
  localparam logic [D-1:0] CAP = {D{1'b1}};
  localparam logic [D-1:0] ONE = D'(1);

  typedef enum logic [2:0] {
    IDLE, UP_RD, UP_CMP, FETCH, FETCH_W, DN_RD, DN_CMP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  cnt_q, cnt_d;
  logic [D-1:0]  k_q, k_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  root_q, root_d;
  logic [LW-1:0] rlvl_q, rlvl_d;

  logic          rd_en, w_en;
  logic [D-1:0]  rd_n, w_n;
  logic [W-1:0]  w_v;
  logic [LW-1:0] rd_lvl, w_lvl;
  logic [2*W-1:0] rd_all [D];
  logic [2*W-1:0] rpair;

  logic [D:0]    k2, cnt_x;
  logic [D-1:0]  par, best_n;
  logic [W-1:0]  par_v, best_v, lft, rgt;
  logic          use_r;

  function automatic logic [LW-1:0] lvl_of(input logic [D-1:0] n);
    lvl_of = '0;
    for (int i = 1; i < D; i++)
      if (n[i]) lvl_of = LW'(i);
  endfunction

  function automatic logic beats(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    return MAX_HEAP ? (a > b) : (a < b);
  endfunction

  function automatic logic [W-1:0] half(input logic [2*W-1:0] p,
                                        input logic hi);
    return hi ? p[2*W-1:W] : p[W-1:0];
  endfunction

  assign rpair  = rd_all[rlvl_q];
  assign k2     = {k_q, 1'b0};
  assign cnt_x  = {1'b0, cnt_q};
  assign par    = k_q >> 1;
  assign par_v  = (par == ONE) ? root_q : half(rpair, par[0]);
  assign lft    = rpair[W-1:0];
  assign rgt    = rpair[2*W-1:W];
  assign use_r  = ({k_q, 1'b1} <= cnt_x) && beats(rgt, lft);
  assign best_v = use_r ? rgt : lft;
  assign best_n = {k_q[D-2:0], use_r};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    cur_d   = cur_q;
    rlvl_d  = rlvl_q;
    rd_en   = 1'b0;
    rd_n    = k_q;
    w_en    = 1'b0;
    w_n     = k_q;
    w_v     = cur_q;
    unique case (state_q)
      IDLE: begin
        if (i_replace) begin
          cur_d = i_new_item;
          k_d   = ONE;
          if (cnt_q == '0) begin
            cnt_d   = ONE;
            state_d = DONE;
          end else begin
            state_d = DN_RD;
          end
        end else if (i_read) begin
          if (cnt_q == ONE) begin
            cnt_d = '0;
          end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - ONE;
            k_d     = cnt_q;
            state_d = FETCH;
          end
        end else if (i_write && cnt_q != CAP) begin
          cnt_d   = cnt_q + ONE;
          cur_d   = i_new_item;
          k_d     = cnt_q + ONE;
          state_d = (cnt_q == '0) ? DONE : UP_RD;
        end
      end
      UP_RD: begin
        rd_en   = 1'b1;
        rd_n    = par;
        rlvl_d  = lvl_of(par);
        state_d = UP_CMP;
      end
      UP_CMP: begin
        if (beats(cur_q, par_v)) begin
          w_en    = 1'b1;
          w_v     = par_v;
          k_d     = par;
          state_d = (par == ONE) ? DONE : UP_RD;
        end else begin
          state_d = DONE;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        rlvl_d  = lvl_of(k_q);
        state_d = FETCH_W;
      end
      FETCH_W: begin
        cur_d   = half(rpair, k_q[0]);
        k_d     = ONE;
        state_d = DN_RD;
      end
      DN_RD: begin
        // A leaf slot takes cur directly; this write ends the operation
        if (k2 > cnt_x) begin
          w_en    = 1'b1;
          state_d = IDLE;
        end else begin
          rd_en   = 1'b1;
          rd_n    = {k_q[D-2:0], 1'b0};
          rlvl_d  = lvl_of(k_q) + LW'(1);
          state_d = DN_CMP;
        end
      end
      DN_CMP: begin
        if (beats(best_v, cur_q)) begin
          w_en    = 1'b1;
          w_v     = best_v;
          k_d     = best_n;
          state_d = DN_RD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        w_en    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign root_d = (w_en && w_n == ONE) ? w_v : root_q;
  assign rd_lvl = lvl_of(rd_n);
  assign w_lvl  = lvl_of(w_n);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      cur_q   <= '0;
      root_q  <= '0;
      rlvl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      root_q  <= root_d;
      rlvl_q  <= rlvl_d;
    end
  end

  assign rd_all[0] = '0;

  for (genvar l = 1; l < D; l++) begin : g_lvl
    localparam int AW = (l > 1) ? l - 1 : 1;
    logic [2*W-1:0] mem [2**AW];
    logic [2*W-1:0] rd_q;
    logic [AW-1:0]  ra, wa;
    logic           re, we;

    assign re = rd_en && (rd_lvl == LW'(l));
    assign we = w_en && (w_lvl == LW'(l));
    assign ra = (l > 1) ? rd_n[AW:1] : '0;
    assign wa = (l > 1) ? w_n[AW:1] : '0;

    always_ff @(posedge CLK) begin
      if (we && !w_n[0]) mem[wa][W-1:0] <= w_v;
      if (we && w_n[0]) mem[wa][2*W-1:W] <= w_v;
      if (re) rd_q <= mem[ra];
    end

    assign rd_all[l] = rd_q;
  end

  assign o_ready    = (state_q == IDLE);
  assign o_full     = (cnt_q == CAP);
  assign o_empty    = (cnt_q == '0);
  assign o_count    = cnt_q;
  assign o_top_item = o_empty ? '0 : root_q;

endmodule
